// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer: drives the BIST side of the memory input mux and checks read data.
// Latency: first op one cycle after start is sampled; 10N op cycles + 1 check cycle, then DONE.
// Backpressure: none; start is ignored while a test is in progress. Optional MBIST_FAIL_LOG_EN keeps a first-mismatch log.
module mbist_march_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              NbarT,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [WIDTH-1:0]  bist_data,
  output logic              bist_we,
  output logic              bist_re,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CHK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    PH_RD = 1'b0,
    PH_WR = 1'b1
  } phase_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  // M3 and M4 walk the address space downwards; all others walk upwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Write background: M1 and M3 write all ones, M0/M2/M4 write all zeros.
  function automatic logic [WIDTH-1:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  endfunction

  // Read expectation: M2 and M4 expect ones left by the previous element.
  function automatic logic [WIDTH-1:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         elem_q, elem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  phase_t             phase_q, phase_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               fail_q, fail_d;

  logic               run;
  logic               start_take;
  logic               mismatch;
  logic               at_end;
  logic [2:0]         elem_nx;

  // Output decode: everything is derived from registered state, so reset zeroes all outputs at once.
  always_comb begin
    run        = (state_q == S_RUN);
    busy       = run || (state_q == S_CHK);
    NbarT      = busy;
    done       = (state_q == S_DONE);
    fail       = fail_q;
    bist_addr  = run ? addr_q : '0;
    bist_we    = run && (phase_q == PH_WR);
    bist_re    = run && (phase_q == PH_RD);
    bist_data  = bist_we ? wr_bg(elem_q) : '0;
    start_take = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    mismatch   = cmp_vld_q && (mem_rdata != exp_q);
  end

  // Sequencer: walks element/address/phase and schedules a compare one cycle after each read.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    cmp_vld_d = 1'b0;
    exp_d     = exp_q;
    fail_d    = fail_q;
    elem_nx   = elem_q + 3'd1;
    at_end    = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);

    // Sticky; a compare pending in CHK still lands as the FSM enters DONE.
    if (mismatch) begin
      fail_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          phase_d = PH_WR;
          fail_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (phase_q == PH_RD) begin
          cmp_vld_d = 1'b1;
          exp_d     = rd_bg(elem_q);
        end
        if ((phase_q == PH_RD) && (elem_q != ELEM_LAST)) begin
          // Read-then-write elements stay on the same address for the write.
          phase_d = PH_WR;
        end else if (!at_end) begin
          addr_d  = elem_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          phase_d = (elem_q == 3'd0) ? PH_WR : PH_RD;
        end else if (elem_q == ELEM_LAST) begin
          // Last M5 read issued; its compare happens in CHK.
          state_d = S_CHK;
          addr_d  = '0;
        end else begin
          // Roll straight into the next element with no gap cycle.
          elem_d  = elem_nx;
          addr_d  = elem_down(elem_nx) ? ADDR_LAST : '0;
          phase_d = PH_RD;
        end
      end
      S_CHK: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Main state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      elem_q    <= 3'd0;
      addr_q    <= '0;
      phase_q   <= PH_WR;
      cmp_vld_q <= 1'b0;
      exp_q     <= '0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      cmp_vld_q <= cmp_vld_d;
      exp_q     <= exp_d;
      fail_q    <= fail_d;
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;

  // Fail log: remember where each read came from and latch the first mismatch only.
  always_comb begin
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (bist_re) begin
      cmp_addr_d = addr_q;
      cmp_elem_d = elem_q;
    end
    if (mismatch && !fail_q) begin
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end
    if (start_take) begin
      fail_addr_d = '0;
      fail_elem_d = 3'd0;
    end
  end

  // Fail log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
`else
  // Without the log, only the sticky fail flag is reported.
  logic unused_start_take;
  assign unused_start_take = start_take;
  assign fail_addr = '0;
  assign fail_elem = 3'd0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl with a 1-cycle-latency memory behind the mux.
// Expected op stream and fail outcome come from a March C- table and an array memory model.
// Random stuck-at faults, random idle gaps and stray start pulses exercise the sequencer.
module tb_mbist_march_ctrl;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int N      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  mem_rdata;
  logic              NbarT;
  logic [ADDR_W-1:0] bist_addr;
  logic [WIDTH-1:0]  bist_data;
  logic              bist_we;
  logic              bist_re;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  mbist_march_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_rdata (mem_rdata),
    .NbarT     (NbarT),
    .bist_addr (bist_addr),
    .bist_data (bist_data),
    .bist_we   (bist_we),
    .bist_re   (bist_re),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  always #5 clk = ~clk;

  // Fault injection: a single stuck-at bit seen on reads of one address.
  bit flt_en  = 1'b0;
  int flt_addr = 0;
  int flt_bit  = 0;
  bit flt_val  = 1'b0;

  function automatic logic [WIDTH-1:0] faulty(input logic [WIDTH-1:0] v, input int a);
    if (flt_en && (a == flt_addr)) v[flt_bit] = flt_val;
    return v;
  endfunction

  // Memory behind the mux; the normal side is idle so only BIST strobes reach it.
  logic [WIDTH-1:0] mem [N];
  always @(posedge clk) begin
    if (NbarT && bist_we) mem[bist_addr] <= bist_data;
    if (NbarT && bist_re) mem_rdata <= faulty(mem[bist_addr], int'(bist_addr));
  end

  // March C- as a table: direction, read background (-1 none), write background (-1 none).
  bit q_we[$];
  int q_addr[$];
  logic [WIDTH-1:0] q_dat[$];
  int q_elem[$];

  function automatic void build_march();
    bit dn[6] = '{0, 0, 0, 1, 1, 0};
    int rd[6] = '{-1, 0, 1, 0, 1, 0};
    int wr[6] = '{0, 1, 0, 1, 0, -1};
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        int a;
        a = dn[e] ? (N - 1 - k) : k;
        if (rd[e] >= 0) begin
          q_we.push_back(1'b0); q_addr.push_back(a);
          q_dat.push_back(rd[e] == 1 ? {WIDTH{1'b1}} : {WIDTH{1'b0}}); q_elem.push_back(e);
        end
        if (wr[e] >= 0) begin
          q_we.push_back(1'b1); q_addr.push_back(a);
          q_dat.push_back(wr[e] == 1 ? {WIDTH{1'b1}} : {WIDTH{1'b0}}); q_elem.push_back(e);
        end
      end
    end
  endfunction

  // Play the op list against an array memory with the current fault; find the first bad read.
  function automatic void predict(output int first_op, output int faddr, output int felem);
    logic [WIDTH-1:0] m [N];
    first_op = -1; faddr = 0; felem = 0;
    for (int i = 0; i < q_we.size(); i++) begin
      if (q_we[i]) m[q_addr[i]] = q_dat[i];
      else if (first_op < 0 && faulty(m[q_addr[i]], q_addr[i]) !== q_dat[i]) begin
        first_op = i; faddr = q_addr[i]; felem = q_elem[i];
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, NbarT, busy, done, fail, bist_re, bist_we, bist_addr, bist_data, fail_addr, fail_elem};
  endfunction

  // One full test starting from IDLE or DONE at a negedge with start low.
  task automatic run_march(input int ign_at, input int hold_cyc, input bit chk_start);
    int fo, fa, fe, nops;
    bit fexp;
    predict(fo, fa, fe);
    nops = q_we.size();
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nops; i++) begin
      start = (i < hold_cyc) || (i == ign_at);
      check("op_re",   bist_re, !q_we[i]);
      check("op_we",   bist_we, q_we[i]);
      check("op_addr", bist_addr, q_addr[i]);
      check("op_data", bist_data, q_we[i] ? q_dat[i] : '0);
      check("op_busy_nbart_done", {busy, NbarT, done}, 3'b110);
      check("op_fail", fail, (fo >= 0) && (i >= fo + 2));
      @(negedge clk);
    end
    start = chk_start;
    check("chk_strobes", {bist_re, bist_we}, 2'b00);
    check("chk_busy_nbart_done", {busy, NbarT, done}, 3'b110);
    check("chk_fail", fail, (fo >= 0) && (nops >= fo + 2));
    @(negedge clk);
    start = 1'b0;
    fexp = (fo >= 0);
    check("done_state", {busy, NbarT, done, bist_re, bist_we}, 5'b00100);
    check("done_fail", fail, fexp);
`ifdef MBIST_FAIL_LOG_EN
    check("done_fail_addr", fail_addr, fexp ? fa : 0);
    check("done_fail_elem", fail_elem, fexp ? fe : 0);
`else
    check("done_fail_log_tied", {fail_addr, fail_elem}, 0);
`endif
  endtask

  initial begin
    int gap;
    build_march();
    check("op_count", q_we.size(), 10 * N);

    // 1: reset and idle
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs", all_outs(), 0);
    end

    // 2: fault-free run with a one-cycle start pulse
    run_march(-1, 0, 1'b0);

    // 3 and 4: bit0 stuck-at-1 at address 5 (order is checked op by op)
    flt_en = 1'b1; flt_addr = 5; flt_bit = 0; flt_val = 1'b1;
    run_march(-1, 0, 1'b0);
    check("t3_fail", fail, 1'b1);
`ifdef MBIST_FAIL_LOG_EN
    check("t3_fail_addr", fail_addr, 5);
    check("t3_fail_elem", fail_elem, 1);
`endif

    // 6b: start held high in DONE after a failing run; fail must clear in the first op cycle
    flt_en = 1'b0;
    run_march(-1, 3, 1'b0);

    // 6a: stray start at cycle 30 and during CHK are ignored
    run_march(30, 0, 1'b1);

    // 5: reset in mid-test, then a fresh passing run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("pre_reset_busy", {busy, NbarT}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", all_outs(), 0);
    run_march(-1, 0, 1'b0);

    // Randomized runs: random fault, idle gap in DONE, stray starts
    for (int r = 0; r < 6; r++) begin
      flt_en   = ($urandom_range(0, 2) != 0);
      flt_addr = $urandom_range(0, N - 1);
      flt_bit  = $urandom_range(0, WIDTH - 1);
      flt_val  = $urandom_range(0, 1);
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("done_hold", {done, busy}, 2'b10);
      end
      run_march($urandom_range(1, 10 * N - 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
